// File: rtl/cdc_hs_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cdc_hs_pkg
//  Description : Shared types and helpers for the toggle req/ack CDC
//                handshake (source side cdc_handshake_tx, destination side
//                cdc_handshake_rx).
//  Contents    : hs_state_t - handshake FSM state encoding
//                cnt_width  - width of the WAIT_ACK timeout counter
//  Revision    : 1.0 - initial release
// ============================================================================
package cdc_hs_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      FAULT    = 2'd2
   } hs_state_t;

   // Counter must hold 0..timeout_cycles-1; never narrower than one bit so a
   // disabled timeout (0) still yields a legal vector.
   function automatic int cnt_width(input int timeout_cycles);
      int w;
      w = $clog2(timeout_cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_handshake_tx_if.sv
`default_nettype none
// ============================================================================
//  Interface   : cdc_handshake_tx_if
//  Description : Local valid/ready producer port plus the crossing req/ack
//                pair of the source-side toggle handshake.
//  Signals     : i_valid, i_data     - producer word offer
//                o_ready             - source block can accept
//                o_xfer_data, o_req  - word and request toggle to destination
//                i_ack               - ack toggle from destination domain
//                o_done, o_fault     - completion pulse / sticky fault
//  Modports    : slave  - the cdc_handshake_tx block
//                master - producer plus destination environment
//  Revision    : 1.0 - initial release
// ============================================================================
interface cdc_handshake_tx_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  i_valid;
   logic [DATA_WIDTH-1:0] i_data;
   logic                  o_ready;
   logic [DATA_WIDTH-1:0] o_xfer_data;
   logic                  o_req;
   logic                  i_ack;
   logic                  o_done;
   logic                  o_fault;

   modport slave (
      input  i_valid, i_data, i_ack,
      output o_ready, o_xfer_data, o_req, o_done, o_fault
   );

   modport master (
      output i_valid, i_data, i_ack,
      input  o_ready, o_xfer_data, o_req, o_done, o_fault
   );
endinterface
`default_nettype wire

// File: rtl/n_stage_synchronizer.sv
`default_nettype none
// ============================================================================
//  Module      : n_stage_synchronizer
//  Description : Plain flop-chain synchronizer for signals asynchronous to
//                i_clk. NUM_STAGE must be at least 2.
//  Ports       : i_clk - destination clock
//                i_rst - asynchronous active-high reset, clears all stages
//                i_d   - asynchronous input
//                o_q   - i_d delayed by NUM_STAGE flops
//  Revision    : 1.0 - initial release
// ============================================================================
module n_stage_synchronizer #(
   parameter int NUM_STAGE  = 2,
   parameter int DATA_WIDTH = 1
) (
   input  wire                   i_clk,
   input  wire                   i_rst,
   input  wire  [DATA_WIDTH-1:0] i_d,
   output logic [DATA_WIDTH-1:0] o_q
);
   logic [NUM_STAGE-1:0][DATA_WIDTH-1:0] r_stage;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_stage <= '0;
      end else begin
         r_stage <= {r_stage[NUM_STAGE-2:0], i_d};
      end
   end

   assign o_q = r_stage[NUM_STAGE-1];
endmodule
`default_nettype wire

// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_handshake_tx
//  Description : Source half of a two-phase (toggle) req/ack CDC handshake.
//                Accepts a word from the local valid/ready port, holds it on
//                o_xfer_data, toggles o_req and waits until the synchronized
//                ack level equals o_req. Timeout or a spurious ack toggle
//                lands in a sticky FAULT state left only through i_rst.
//  Ports       : i_clk, i_rst - clock and asynchronous active-high reset
//                bus (slave)  - i_valid/i_data/o_ready producer port,
//                               o_xfer_data/o_req/i_ack crossing pair,
//                               o_done pulse, o_fault level
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_handshake_tx
   import cdc_hs_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int NUM_SYNC       = 3,
   parameter int TIMEOUT_CYCLES = 255
) (
   input wire                i_clk,
   input wire                i_rst,
   cdc_handshake_tx_if.slave bus
);
   localparam int                 c_cnt_w      = cnt_width(TIMEOUT_CYCLES);
   localparam bit                 c_tmo_en     = (TIMEOUT_CYCLES > 0);
   localparam int                 c_tmo_last_i = c_tmo_en ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [c_cnt_w-1:0] c_tmo_last   = c_tmo_last_i[c_cnt_w-1:0];

   hs_state_t             r_state, w_state_nxt;
   logic                  r_req, w_req_nxt;
   logic [DATA_WIDTH-1:0] r_xfer_data, w_xfer_data_nxt;
   logic [c_cnt_w-1:0]    r_cnt, w_cnt_nxt;
   logic                  r_done, w_done_nxt;
   logic                  w_ack_s;
   logic                  w_tmo_hit;

   // Raw i_ack is never looked at; only its synchronized copy.
   n_stage_synchronizer #(
      .NUM_STAGE  (NUM_SYNC),
      .DATA_WIDTH (1)
   ) u_ack_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (bus.i_ack),
      .o_q   (w_ack_s)
   );

   assign w_tmo_hit = c_tmo_en && (r_cnt == c_tmo_last);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_req       <= 1'b0;
         r_xfer_data <= '0;
         r_cnt       <= '0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_req       <= w_req_nxt;
         r_xfer_data <= w_xfer_data_nxt;
         r_cnt       <= w_cnt_nxt;
         r_done      <= w_done_nxt;
      end
   end

   // Completion is a level comparison of ack against req, so a sampled glitch
   // on the way can only delay completion, never produce a second o_done.
   always_comb begin
      w_state_nxt     = r_state;
      w_req_nxt       = r_req;
      w_xfer_data_nxt = r_xfer_data;
      w_cnt_nxt       = r_cnt;
      w_done_nxt      = 1'b0;
      case (r_state)
         IDLE: begin
            // An ack level change with no request outstanding beats accept.
            if (w_ack_s != r_req) begin
               w_state_nxt = FAULT;
            end else if (bus.i_valid) begin
               w_state_nxt     = WAIT_ACK;
               w_req_nxt       = ~r_req;
               w_xfer_data_nxt = bus.i_data;
               w_cnt_nxt       = '0;
            end
         end
         WAIT_ACK: begin
            // Ack is tested before the timeout so a coincident match completes.
            if (w_ack_s == r_req) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end else if (w_tmo_hit) begin
               w_state_nxt = FAULT;
            end else if (c_tmo_en) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         FAULT: begin
            w_state_nxt = FAULT;
         end
         default: begin
            w_state_nxt = FAULT;
         end
      endcase
   end

   assign bus.o_ready     = (r_state == IDLE);
   assign bus.o_fault     = (r_state == FAULT);
   assign bus.o_done      = r_done;
   assign bus.o_req       = r_req;
   assign bus.o_xfer_data = r_xfer_data;
endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdc_handshake_tx
//  Description : Self-checking bench for cdc_handshake_tx. dut_a (timeout 16)
//                runs directed scenarios then randomized traffic, checked each
//                cycle against a transaction-level model; dut_b (timeout 4)
//                covers an ack match on the timeout edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_handshake_tx;
   localparam int DW    = 8;
   localparam int NS    = 3;
   localparam int TMO_A = 16;
   localparam int TMO_B = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   cdc_handshake_tx_if #(.DATA_WIDTH(DW)) bus_a ();
   cdc_handshake_tx_if #(.DATA_WIDTH(DW)) bus_b ();

   logic ack_loop_a;
   logic ack_man_a;
   assign bus_a.i_ack = ack_loop_a ? bus_a.o_req : ack_man_a;
   assign bus_b.i_ack = bus_b.o_req;

   cdc_handshake_tx #(.DATA_WIDTH(DW), .NUM_SYNC(NS), .TIMEOUT_CYCLES(TMO_A)) dut_a (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus_a)
   );

   cdc_handshake_tx #(.DATA_WIDTH(DW), .NUM_SYNC(NS), .TIMEOUT_CYCLES(TMO_B)) dut_b (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- transaction-level model of dut_a ----------------
   // m_ackq holds the i_ack level seen at each past edge; the DUT acts on
   // the level from NS edges ago.
   logic          m_busy, m_fault, m_done, m_req;
   logic [DW-1:0] m_data;
   int            m_elapsed;
   logic          m_ackq[$];
   logic          mon_en = 1'b0;

   task automatic model_reset();
      m_busy    = 1'b0;
      m_fault   = 1'b0;
      m_done    = 1'b0;
      m_req     = 1'b0;
      m_data    = '0;
      m_elapsed = 0;
      m_ackq    = {};
      repeat (NS) m_ackq.push_back(1'b0);
   endtask

   task automatic model_step();
      logic ack_seen;
      if (rst) begin
         model_reset();
         return;
      end
      ack_seen = m_ackq.pop_front();
      m_ackq.push_back(bus_a.i_ack);
      m_done = 1'b0;
      if (!m_fault) begin
         if (!m_busy) begin
            if (ack_seen != m_req) begin
               m_fault = 1'b1;
            end else if (bus_a.i_valid) begin
               m_busy    = 1'b1;
               m_req     = ~m_req;
               m_data    = bus_a.i_data;
               m_elapsed = 0;
            end
         end else begin
            m_elapsed++;
            if (ack_seen == m_req) begin
               m_busy = 1'b0;
               m_done = 1'b1;
            end else if (m_elapsed == TMO_A) begin
               m_fault = 1'b1;
            end
         end
      end
   endtask

   // Inputs change only at posedge+1, so at the negedge they hold the values
   // the next posedge will sample: compare first, then advance the model.
   always @(negedge clk) begin
      if (rst) model_reset();
      if (mon_en) begin
         chk("mdl_ready", bus_a.o_ready, !m_busy && !m_fault);
         chk("mdl_req",   bus_a.o_req,   m_req);
         chk("mdl_data",  bus_a.o_xfer_data, m_data);
         chk("mdl_done",  bus_a.o_done,  m_done);
         chk("mdl_fault", bus_a.o_fault, m_fault);
         chk("done_fault_excl", bus_a.o_done & bus_a.o_fault, 0);
      end
      model_step();
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      ack_man_a     = 1'b0;
      bus_a.i_valid = 1'b0;
      bus_b.i_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   int   n_done;
   logic pend;
   int   dly;

   initial begin
      bus_a.i_valid = 1'b0;
      bus_a.i_data  = '0;
      bus_b.i_valid = 1'b0;
      bus_b.i_data  = '0;
      ack_loop_a    = 1'b1;
      ack_man_a     = 1'b0;
      do_reset();
      mon_en = 1'b1;

      // Reset state and single loopback transfer
      chk("rst_ready", bus_a.o_ready, 1);
      chk("rst_req",   bus_a.o_req, 0);
      chk("rst_data",  bus_a.o_xfer_data, 0);
      chk("rst_done",  bus_a.o_done, 0);
      chk("rst_fault", bus_a.o_fault, 0);
      bus_a.i_valid = 1'b1;
      bus_a.i_data  = 8'hA5;
      tick();
      bus_a.i_valid = 1'b0;
      bus_a.i_data  = 8'h00;
      chk("t1_req",   bus_a.o_req, 1);
      chk("t1_data",  bus_a.o_xfer_data, 8'hA5);
      chk("t1_ready", bus_a.o_ready, 0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("t1_done_early", bus_a.o_done, 0);
      end
      tick();
      chk("t1_done",        bus_a.o_done, 1);
      chk("t1_ready_again", bus_a.o_ready, 1);
      tick();
      chk("t1_done_one_cycle", bus_a.o_done, 0);

      // Back-to-back words with i_valid held high
      do_reset();
      n_done        = 0;
      bus_a.i_valid = 1'b1;
      bus_a.i_data  = 8'h01;
      for (int k = 0; k < 15; k++) begin
         tick();
         chk("t2_req",  bus_a.o_req, (((k / 5) % 2) == 0) ? 1 : 0);
         chk("t2_data", bus_a.o_xfer_data, 1 + k / 5);
         chk("t2_done", bus_a.o_done, (k % 5) == 4);
         if (bus_a.o_done) n_done++;
         bus_a.i_data = 8'(1 + (k + 1) / 5);
         if (k == 14) bus_a.i_valid = 1'b0;
      end
      chk("t2_done_count", n_done, 3);

      // Timeout with ack never returning
      do_reset();
      ack_loop_a    = 1'b0;
      bus_a.i_valid = 1'b1;
      bus_a.i_data  = 8'h96;
      tick();
      bus_a.i_valid = 1'b0;
      chk("t3_req", bus_a.o_req, 1);
      n_done = 0;
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (bus_a.o_done) n_done++;
         chk("t3_fault_early", bus_a.o_fault, 0);
      end
      tick();
      chk("t3_fault", bus_a.o_fault, 1);
      chk("t3_ready", bus_a.o_ready, 0);
      bus_a.i_valid = 1'b1;
      repeat (4) begin
         tick();
         if (bus_a.o_done) n_done++;
         chk("t3_fault_sticky", bus_a.o_fault, 1);
         chk("t3_ready_low",    bus_a.o_ready, 0);
         chk("t3_req_frozen",   bus_a.o_req, 1);
         chk("t3_data_frozen",  bus_a.o_xfer_data, 8'h96);
      end
      chk("t3_no_done", n_done, 0);
      do_reset();
      chk("t3_fault_cleared", bus_a.o_fault, 0);
      chk("t3_ready_cleared", bus_a.o_ready, 1);

      // Spurious ack toggle while idle
      ack_man_a = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("t4_fault_early", bus_a.o_fault, 0);
         chk("t4_ready_early", bus_a.o_ready, 1);
      end
      bus_a.i_valid = 1'b1;
      bus_a.i_data  = 8'h5A;
      tick();
      chk("t4_fault",     bus_a.o_fault, 1);
      chk("t4_ready",     bus_a.o_ready, 0);
      chk("t4_no_accept", bus_a.o_req, 0);
      chk("t4_data",      bus_a.o_xfer_data, 0);
      do_reset();

      // Reset in the middle of WAIT_ACK
      ack_loop_a    = 1'b1;
      bus_a.i_valid = 1'b1;
      bus_a.i_data  = 8'h3C;
      tick();
      bus_a.i_valid = 1'b0;
      tick();
      tick();
      chk("t6_req_before", bus_a.o_req, 1);
      rst = 1'b1;
      #1;
      chk("t6_req_async",   bus_a.o_req, 0);
      chk("t6_data_async",  bus_a.o_xfer_data, 0);
      chk("t6_fault_async", bus_a.o_fault, 0);
      chk("t6_done_async",  bus_a.o_done, 0);
      tick();
      rst = 1'b0;
      chk("t6_ready_release", bus_a.o_ready, 1);
      bus_a.i_valid = 1'b1;
      bus_a.i_data  = 8'h77;
      tick();
      bus_a.i_valid = 1'b0;
      chk("t6_req_next",  bus_a.o_req, 1);
      chk("t6_data_next", bus_a.o_xfer_data, 8'h77);
      repeat (3) tick();
      tick();
      chk("t6_done_next", bus_a.o_done, 1);
      tick();

      // Ack match on the same edge as the timeout (dut_b, timeout 4)
      bus_b.i_valid = 1'b1;
      bus_b.i_data  = 8'hC3;
      tick();
      bus_b.i_valid = 1'b0;
      chk("t5_req", bus_b.o_req, 1);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("t5_done_early",  bus_b.o_done, 0);
         chk("t5_fault_early", bus_b.o_fault, 0);
      end
      tick();
      chk("t5_done",  bus_b.o_done, 1);
      chk("t5_fault", bus_b.o_fault, 0);
      chk("t5_ready", bus_b.o_ready, 1);
      tick();
      chk("t5_fault_after", bus_b.o_fault, 0);
      chk("t5_done_after",  bus_b.o_done, 0);

      // Randomized traffic with a delayed-ack destination
      ack_man_a  = bus_a.o_req;
      ack_loop_a = 1'b0;
      pend       = 1'b0;
      dly        = 0;
      for (int i = 0; i < 600; i++) begin
         tick();
         if (rst) begin
            rst = 1'b0;
         end else if (bus_a.o_fault) begin
            rst           = 1'b1;
            ack_man_a     = 1'b0;
            pend          = 1'b0;
            bus_a.i_valid = 1'b0;
            continue;
         end
         bus_a.i_valid = ($urandom_range(0, 2) != 0);
         bus_a.i_data  = 8'($urandom);
         if (pend) begin
            if (dly == 0) begin
               ack_man_a = bus_a.o_req;
               pend      = 1'b0;
            end else begin
               dly--;
            end
         end else if (ack_man_a != bus_a.o_req) begin
            pend = 1'b1;
            dly  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 20))
                                                : int'($urandom_range(0, 3));
         end else if (bus_a.o_ready && ($urandom_range(0, 149) == 0)) begin
            ack_man_a = ~ack_man_a;
         end
      end
      rst = 1'b0;
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/cdc_handshake_tx.md
Name: cdc_handshake_tx

Overview:
Source-side half of a two-phase (toggle) req/ack clock-domain-crossing handshake. Captures a data word from a local valid/ready interface and holds it stable on o_xfer_data. Toggles o_req, then waits until the destination's ack toggle, synchronized into i_clk, matches o_req. Sits in the sending clock domain; the receiving domain samples o_req/o_xfer_data through its own synchronizer and returns i_ack.

Parameters:
DATA_WIDTH, 8, width of transferred word
NUM_SYNC, 3, flop stages on i_ack before use (>=2)
TIMEOUT_CYCLES, 255, max cycles in WAIT_ACK before fault; 0 disables timeout

Ports:
i_clk  input  1  clock, all logic on posedge
i_rst  input  1  asynchronous, active-high reset
i_valid  input  1  local producer has a word
i_data  input  DATA_WIDTH  word to send, sampled on accept
o_ready  output  1  block can accept; high only in IDLE
o_xfer_data  output  DATA_WIDTH  registered word presented to destination domain
o_req  output  1  registered request toggle level
i_ack  input  1  ack toggle from destination domain (asynchronous to i_clk)
o_done  output  1  one-cycle pulse: transfer acknowledged
o_fault  output  1  sticky protocol/timeout fault level

Behaviour:
- Reset (async assert, i_clk-synchronous release by system): state=IDLE, o_req=0, o_xfer_data=0, ack sync flops=0, timeout counter=0, o_done=0, o_fault=0. o_ready=1 immediately after reset.
- ack_s = i_ack after NUM_SYNC flops; only ack_s is used, never raw i_ack.
- States: IDLE, WAIT_ACK, FAULT. o_ready = (state==IDLE).
- IDLE: on edge with i_valid&&o_ready: o_xfer_data<=i_data, o_req<=~o_req, counter<=0, state->WAIT_ACK. If ack_s!=o_req in IDLE (spurious ack toggle), state->FAULT; this check takes priority over accept.
- WAIT_ACK: o_xfer_data and o_req held constant. If ack_s==o_req: state->IDLE, o_done=1 for exactly that next cycle. Otherwise counter+1; if TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 with no match, state->FAULT. Ack match and timeout on same edge: ack wins (done, no fault).
- FAULT: o_fault=1, o_ready=0, o_req/o_xfer_data frozen; exit only via i_rst.
- Comparison is level (ack_s==o_req), not edge detection; a missed/glitched intermediate sample cannot cause a double-done.
- Latency (i_ack looped to o_req): accept at edge E0; ack_s matches after edge E0+NUM_SYNC; state->IDLE and o_done=1 after edge E0+NUM_SYNC+1; next accept possible at E0+NUM_SYNC+2. Max throughput one word per NUM_SYNC+2 cycles.
- i_data/i_valid changes while in WAIT_ACK are ignored.
- Counter width $clog2(TIMEOUT_CYCLES+1), minimum 1; no wrap (saturates into FAULT).
- Reset mid-transfer: abandons transfer, o_req returns 0; system requirement: destination side reset concurrently so its ack toggle also returns 0.
- o_done and o_fault never both 1.

Decomposition:
- Shared package cdc_hs_pkg: state enum (IDLE=2'd0, WAIT_ACK=2'd1, FAULT=2'd2), and a function for counter width. The companion cdc_handshake_rx uses the same package.
- One sub-module: instantiate the existing n_stage_synchronizer (NUM_STAGE=NUM_SYNC, DATA_WIDTH=1) for i_ack; the rest is one FSM plus counter in this module.

Test Plan:
- Loopback i_ack=o_req, NUM_SYNC=3, send 8'hA5 at edge 0 -> o_req 0->1 and o_xfer_data=8'hA5 after edge 0, o_done pulse after edge 4, o_ready high again after edge 4.
- Back-to-back i_valid held high, data 8'h01,8'h02,8'h03 via loopback -> exactly 3 done pulses spaced 5 cycles, o_req toggles 1,0,1, each word stable for its full WAIT_ACK.
- i_ack tied 0 after one toggle, TIMEOUT_CYCLES=16 -> o_fault rises 16 cycles after accept, o_ready stays 0, o_done never pulses; only i_rst clears.
- i_ack toggled in IDLE with no request -> FAULT NUM_SYNC+1 cycles later, no accept occurs even with i_valid=1.
- Ack match arriving on exact timeout edge (TIMEOUT_CYCLES=4, delay ack so ack_s matches on the counter=3 edge) -> o_done=1, o_fault stays 0.
- Assert i_rst mid-WAIT_ACK with o_req=1 -> o_req, o_xfer_data, o_fault go 0 asynchronously, o_ready=1 after release, next transfer completes normally.
